// File: rtl/fp_format_converter_pkg.sv
// Shared helpers for IEEE-754-style binary formats.
//   bias()       exponent bias for an exponent field of nx bits
//   fmt_width()  total encoded width {sign, exponent, mantissa}
//   max_int()    larger of two integers, for sizing intermediate fields
//   qnan_bits()  canonical quiet NaN (sign 0) for a format, right-aligned
//                in an FP_MAXW-bit vector
//   rne_up()     round-to-nearest-even increment decision
package fp;

  localparam int FP_MAXW = 128;

  function automatic int bias(input int nx);
    return (1 << (nx - 1)) - 1;
  endfunction

  function automatic int fmt_width(input int nx, input int nm);
    return 1 + nx + nm;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Exponent all ones, mantissa MSB (quiet bit) set, rest zero.
  function automatic logic [FP_MAXW-1:0] qnan_bits(input int nx, input int nm);
    logic [FP_MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < nx; i++) begin
      r[nm + i] = 1'b1;
    end
    r[nm - 1] = 1'b1;
    return r;
  endfunction

  // Increment when the guard bit is set and either something below it is
  // nonzero or the kept value is odd (ties go to even).
  function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/fp_format_converter_if.sv
// Bus bundle for one converter instance.
//   master: drives in_valid/in_fp, observes the registered result
//   slave : the converter side
//   IW/OW : encoded input/output widths
interface fp_format_converter_if
  import fp::*;
#(
  parameter int IW = fmt_width(8, 23),
  parameter int OW = fmt_width(11, 52)
) ();

  logic          in_valid;
  logic [IW-1:0] in_fp;
  logic          out_valid;
  logic [OW-1:0] out_fp;
  logic          out_inexact;
  logic          out_overflow;

  modport master (
    output in_valid, in_fp,
    input  out_valid, out_fp, out_inexact, out_overflow
  );

  modport slave (
    input  in_valid, in_fp,
    output out_valid, out_fp, out_inexact, out_overflow
  );

endinterface

// File: rtl/fp_format_converter_clz.sv
// Leading-zero counter.
//   vec   : N-bit input vector
//   count : number of zeros above the most significant set bit;
//           N when vec is all zeros
module clz_mod #(
  parameter int  N  = 32,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  vec,
  output logic [CW-1:0] count
);

  // Scan upward; the highest set bit is the last one to overwrite count.
  always_comb begin
    count = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (vec[i]) count = CW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/fp_format_converter.sv
// Floating-point format converter, one register stage.
//   clk, rst_n   : clock (rising edge), async active-low reset
//   in_valid     : in_fp is valid this cycle
//   in_fp        : {sign, exponent[INX], mantissa[INM]}
//   out_valid    : in_valid delayed by one cycle
//   out_fp       : {sign, exponent[ONX], mantissa[ONM]}, held while idle
//   out_inexact  : rounding discarded nonzero bits
//   out_overflow : finite input became infinity
module fp_format_converter
  import fp::*;
#(
  parameter int INX = 8,
  parameter int INM = 23,
  parameter int ONX = 11,
  parameter int ONM = 52
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [INX+INM:0] in_fp,
  output logic             out_valid,
  output logic [ONX+ONM:0] out_fp,
  output logic             out_inexact,
  output logic             out_overflow
);

  localparam int IW   = fmt_width(INX, INM);
  localparam int OW   = fmt_width(ONX, ONM);
  localparam int EW   = max_int(INX, ONX) + 2;  // signed working exponent
  localparam int SW   = INM + 1;                // significand incl. hidden bit
  localparam int CW   = $clog2(SW + 1);
  localparam int XW   = ONM + 3;                // hidden, mantissa, guard, sticky
  localparam int AW   = max_int(SW, XW);        // alignment scratch width
  localparam int SUMW = ONM + 2;

  localparam bit SAME_FMT = (INX == ONX) && (INM == ONM);

  localparam logic signed [EW-1:0] BIAS_IN  = EW'(bias(INX));
  localparam logic signed [EW-1:0] BIAS_OUT = EW'(bias(ONX));
  localparam logic signed [EW-1:0] EMAX_S   = EW'((1 << ONX) - 1);
  localparam logic signed [EW-1:0] XW_S     = EW'(XW);
  localparam logic signed [EW-1:0] ONE_S    = EW'(1);
  localparam logic [FP_MAXW-1:0]   QNAN     = qnan_bits(ONX, ONM);

  // Unpack
  logic           sgn;
  logic [INX-1:0] exp_in;
  logic [INM-1:0] man_in;
  logic           exp_zero;
  logic           exp_ones;
  logic [SW-1:0]  sig;
  logic [CW-1:0]  lz;

  assign sgn      = in_fp[IW-1];
  assign exp_in   = in_fp[INX+INM-1 -: INX];
  assign man_in   = in_fp[INM-1:0];
  assign exp_zero = (exp_in == '0);
  assign exp_ones = &exp_in;
  assign sig      = {~exp_zero, man_in};

  // Normal inputs count 0; subnormals count how far the leading one must
  // move to reach the hidden-bit position.
  clz_mod #(.N(SW)) u_clz (
    .vec   (sig),
    .count (lz)
  );

  logic [SW-1:0]          nsig;
  logic [AW-1:0]          al;
  logic [XW-1:0]          ext;
  logic [EW-1:0]          exp_eff;
  logic signed [EW-1:0]   eb;
  logic                   sub;
  logic signed [EW-1:0]   sh_s;
  logic signed [EW-1:0]   sh_c;
  logic [XW-1:0]          shifted;
  logic                   lost;
  logic [XW-1:0]          rnd_in;
  logic [ONM:0]           keep;
  logic                   up;
  logic [SUMW-1:0]        sum;
  logic [ONM-1:0]         man_r;
  logic signed [EW-1:0]   exp_r;
  logic                   ovf;
  logic                   inexact;
  logic [ONM-1:0]         nan_man;
  logic [OW-1:0]          res_fp;
  logic                   res_inx;
  logic                   res_ovf;

  always_comb begin
    // Normalize and rebias. Exponent field 0 behaves as 1 for subnormals.
    nsig    = sig << lz;
    exp_eff = exp_zero ? EW'(1) : EW'(exp_in);
    eb      = signed'(exp_eff) - BIAS_IN - signed'(EW'(lz)) + BIAS_OUT;

    // Left-align into the output grid: everything below the guard bit
    // collapses into sticky.
    al  = AW'(nsig) << (AW - SW);
    ext = {al[AW-1 -: XW-1], |al[AW-XW:0]};

    // Output subnormal: shift right by 1-eb, folding lost bits into sticky.
    sub     = eb[EW-1] || (eb == '0);
    sh_s    = '0;
    sh_c    = '0;
    shifted = '0;
    lost    = 1'b0;
    rnd_in  = ext;
    if (sub) begin
      sh_s    = ONE_S - eb;
      sh_c    = (sh_s > XW_S) ? XW_S : sh_s;
      shifted = ext >> sh_c;
      lost    = |(ext & ~({XW{1'b1}} << sh_c));
      rnd_in  = {shifted[XW-1:1], shifted[0] | lost};
    end

    keep    = rnd_in[XW-1:2];
    inexact = rnd_in[1] | rnd_in[0];
    up      = rne_up(keep[0], rnd_in[1], rnd_in[0]);
    sum     = {1'b0, keep} + SUMW'(up);
    man_r   = sum[ONM-1:0];

    // A carry out of the hidden bit only happens on the normal path; on the
    // subnormal path a set hidden bit means we rounded up to min normal.
    if (sum[ONM+1]) begin
      exp_r = eb + ONE_S;
    end else if (sub) begin
      exp_r = sum[ONM] ? ONE_S : '0;
    end else begin
      exp_r = eb;
    end
    ovf = (exp_r >= EMAX_S);

    // NaN payload left-aligned; narrowing drops the low payload bits.
    nan_man = ONM'({man_in, {ONM{1'b0}}} >> INM);

    res_fp  = '0;
    res_inx = 1'b0;
    res_ovf = 1'b0;
    if (exp_ones) begin
      if (man_in == '0) begin
        res_fp = {sgn, {ONX{1'b1}}, {ONM{1'b0}}};
      end else begin
        res_fp = {sgn, QNAN[ONX+ONM-1:0] | {{ONX{1'b0}}, nan_man}};
      end
    end else if (exp_zero && (man_in == '0)) begin
      res_fp = {sgn, {(OW-1){1'b0}}};
    end else if (ovf) begin
      res_fp  = {sgn, {ONX{1'b1}}, {ONM{1'b0}}};
      res_inx = 1'b1;
      res_ovf = 1'b1;
    end else begin
      res_fp  = {sgn, exp_r[ONX-1:0], man_r};
      res_inx = inexact;
    end

    // Identical formats: keep the bit pattern untouched, signalling NaNs too.
    if (SAME_FMT) begin
      res_fp  = OW'(in_fp);
      res_inx = 1'b0;
      res_ovf = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_fp       <= '0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_fp       <= res_fp;
        out_inexact  <= res_inx;
        out_overflow <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fp_format_converter.sv
module tb_fp_format_converter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fp_format_converter_if #(.IW(32), .OW(64)) fwd_bus ();
  fp_format_converter_if #(.IW(64), .OW(32)) rev_bus ();
  fp_format_converter_if #(.IW(32), .OW(32)) pass_bus ();

  logic [31:0] clz_vec;
  logic [5:0]  clz_cnt;

  fp_format_converter #(.INX(8), .INM(23), .ONX(11), .ONM(52)) u_fwd (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (fwd_bus.in_valid),
    .in_fp        (fwd_bus.in_fp),
    .out_valid    (fwd_bus.out_valid),
    .out_fp       (fwd_bus.out_fp),
    .out_inexact  (fwd_bus.out_inexact),
    .out_overflow (fwd_bus.out_overflow)
  );

  fp_format_converter #(.INX(11), .INM(52), .ONX(8), .ONM(23)) u_rev (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (rev_bus.in_valid),
    .in_fp        (rev_bus.in_fp),
    .out_valid    (rev_bus.out_valid),
    .out_fp       (rev_bus.out_fp),
    .out_inexact  (rev_bus.out_inexact),
    .out_overflow (rev_bus.out_overflow)
  );

  fp_format_converter #(.INX(8), .INM(23), .ONX(8), .ONM(23)) u_pass (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (pass_bus.in_valid),
    .in_fp        (pass_bus.in_fp),
    .out_valid    (pass_bus.out_valid),
    .out_fp       (pass_bus.out_fp),
    .out_inexact  (pass_bus.out_inexact),
    .out_overflow (pass_bus.out_overflow)
  );

  clz_mod #(.N(32)) u_clz (
    .vec   (clz_vec),
    .count (clz_cnt)
  );

  task automatic fwd_cycle(input logic vld, input logic [31:0] v);
    @(negedge clk);
    fwd_bus.in_valid = vld;
    fwd_bus.in_fp    = v;
    @(posedge clk);
    #1;
  endtask

  task automatic rev_cycle(input logic vld, input logic [63:0] v);
    @(negedge clk);
    rev_bus.in_valid = vld;
    rev_bus.in_fp    = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pass_cycle(input logic vld, input logic [31:0] v);
    @(negedge clk);
    pass_bus.in_valid = vld;
    pass_bus.in_fp    = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fwd_bus.in_valid  = 1'b1;
    fwd_bus.in_fp     = 32'h3F80_0000;
    rev_bus.in_valid  = 1'b1;
    rev_bus.in_fp     = 64'h7FEF_FFFF_FFFF_FFFF;
    pass_bus.in_valid = 1'b1;
    pass_bus.in_fp    = 32'h3F80_0000;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({fwd_bus.out_valid, fwd_bus.out_fp, fwd_bus.out_inexact, fwd_bus.out_overflow} !== 67'd0) begin
      failures++;
      $display("FAIL reset_fwd: got valid=%b fp=%h inx=%b ovf=%b, expected all zero",
               fwd_bus.out_valid, fwd_bus.out_fp, fwd_bus.out_inexact, fwd_bus.out_overflow);
    end
    checks++;
    if ({rev_bus.out_valid, rev_bus.out_fp, rev_bus.out_inexact, rev_bus.out_overflow} !== 35'd0) begin
      failures++;
      $display("FAIL reset_rev: got valid=%b fp=%h inx=%b ovf=%b, expected all zero",
               rev_bus.out_valid, rev_bus.out_fp, rev_bus.out_inexact, rev_bus.out_overflow);
    end
    @(negedge clk);
    rst_n             = 1'b1;
    fwd_bus.in_valid  = 1'b0;
    rev_bus.in_valid  = 1'b0;
    pass_bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (fwd_bus.out_valid !== 1'b0 || fwd_bus.out_fp !== 64'd0) begin
      failures++;
      $display("FAIL reset_discard: got valid=%b fp=%h, expected valid=0 fp=0",
               fwd_bus.out_valid, fwd_bus.out_fp);
    end
    fwd_cycle(1'b1, 32'h3F80_0000);
    checks++;
    if (fwd_bus.out_valid !== 1'b1 || fwd_bus.out_fp !== 64'h3FF0_0000_0000_0000) begin
      failures++;
      $display("FAIL reset_first_valid: got valid=%b fp=%h, expected valid=1 fp=3ff0000000000000",
               fwd_bus.out_valid, fwd_bus.out_fp);
    end
  endtask

  task automatic test_widen();
    logic [31:0] vin  [11] = '{32'h3F80_0000, 32'h8000_0000, 32'h0000_0001, 32'h7FC0_0000,
                               32'h7F80_0001, 32'hFF80_0000, 32'h007F_FFFF, 32'h0080_0000,
                               32'h7F7F_FFFF, 32'hC020_0000, 32'h8000_0001};
    logic [63:0] vexp [11] = '{64'h3FF0_0000_0000_0000, 64'h8000_0000_0000_0000,
                               64'h36A0_0000_0000_0000, 64'h7FF8_0000_0000_0000,
                               64'h7FF8_0000_2000_0000, 64'hFFF0_0000_0000_0000,
                               64'h380F_FFFF_C000_0000, 64'h3810_0000_0000_0000,
                               64'h47EF_FFFF_E000_0000, 64'hC004_0000_0000_0000,
                               64'hB6A0_0000_0000_0000};
    for (int i = 0; i < 11; i++) begin
      fwd_cycle(1'b1, vin[i]);
      checks++;
      if (fwd_bus.out_valid !== 1'b1 || fwd_bus.out_fp !== vexp[i] ||
          fwd_bus.out_inexact !== 1'b0 || fwd_bus.out_overflow !== 1'b0) begin
        failures++;
        $display("FAIL widen[%0d] in=%h: got valid=%b fp=%h inx=%b ovf=%b, expected valid=1 fp=%h inx=0 ovf=0",
                 i, vin[i], fwd_bus.out_valid, fwd_bus.out_fp, fwd_bus.out_inexact,
                 fwd_bus.out_overflow, vexp[i]);
      end
    end
  endtask

  task automatic test_narrow();
    logic [63:0] vin  [13] = '{64'h3FF0_0000_0000_0000, 64'h3FF0_0000_1000_0000,
                               64'h3FF0_0000_3000_0000, 64'h7FEF_FFFF_FFFF_FFFF,
                               64'h3FFF_FFFF_F000_0000, 64'h36A0_0000_0000_0000,
                               64'h3690_0000_0000_0000, 64'h380F_FFFF_F000_0000,
                               64'hBFF0_0000_0000_0000, 64'hFFF0_0000_0000_0000,
                               64'h7FF8_0000_0000_0001, 64'h8000_0000_0000_0000,
                               64'h3690_0000_0000_0001};
    logic [31:0] vexp [13] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0002, 32'h7F80_0000,
                               32'h4000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0080_0000,
                               32'hBF80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h8000_0000,
                               32'h0000_0001};
    // {overflow, inexact}
    logic [1:0]  vflg [13] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b01, 2'b00, 2'b01, 2'b01,
                               2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    for (int i = 0; i < 13; i++) begin
      rev_cycle(1'b1, vin[i]);
      checks++;
      if (rev_bus.out_valid !== 1'b1 || rev_bus.out_fp !== vexp[i] ||
          {rev_bus.out_overflow, rev_bus.out_inexact} !== vflg[i]) begin
        failures++;
        $display("FAIL narrow[%0d] in=%h: got valid=%b fp=%h ovf,inx=%b%b, expected valid=1 fp=%h ovf,inx=%b",
                 i, vin[i], rev_bus.out_valid, rev_bus.out_fp, rev_bus.out_overflow,
                 rev_bus.out_inexact, vexp[i], vflg[i]);
      end
    end
  endtask

  task automatic test_hold();
    fwd_cycle(1'b1, 32'hC020_0000);
    fwd_cycle(1'b0, 32'h3F80_0000);
    checks++;
    if (fwd_bus.out_valid !== 1'b0 || fwd_bus.out_fp !== 64'hC004_0000_0000_0000) begin
      failures++;
      $display("FAIL hold_fwd: got valid=%b fp=%h, expected valid=0 fp=c004000000000000",
               fwd_bus.out_valid, fwd_bus.out_fp);
    end
    rev_cycle(1'b1, 64'h7FEF_FFFF_FFFF_FFFF);
    rev_cycle(1'b0, 64'h3FF0_0000_0000_0000);
    rev_cycle(1'b0, 64'h3FF0_0000_0000_0000);
    checks++;
    if (rev_bus.out_valid !== 1'b0 || rev_bus.out_fp !== 32'h7F80_0000 ||
        rev_bus.out_overflow !== 1'b1 || rev_bus.out_inexact !== 1'b1) begin
      failures++;
      $display("FAIL hold_rev_flags: got valid=%b fp=%h ovf=%b inx=%b, expected valid=0 fp=7f800000 ovf=1 inx=1",
               rev_bus.out_valid, rev_bus.out_fp, rev_bus.out_overflow, rev_bus.out_inexact);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] vin  [4] = '{64'h7FEF_FFFF_FFFF_FFFF, 64'h3FF0_0000_0000_0000,
                              64'h3FF0_0000_3000_0000, 64'h0000_0000_0000_0000};
    logic [31:0] vexp [4] = '{32'h7F80_0000, 32'h3F80_0000, 32'h3F80_0002, 32'h0000_0000};
    logic [1:0]  vflg [4] = '{2'b11, 2'b00, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      rev_cycle(1'b1, vin[i]);
      checks++;
      if (rev_bus.out_valid !== 1'b1 || rev_bus.out_fp !== vexp[i] ||
          {rev_bus.out_overflow, rev_bus.out_inexact} !== vflg[i]) begin
        failures++;
        $display("FAIL b2b[%0d]: got valid=%b fp=%h ovf,inx=%b%b, expected valid=1 fp=%h ovf,inx=%b",
                 i, rev_bus.out_valid, rev_bus.out_fp, rev_bus.out_overflow,
                 rev_bus.out_inexact, vexp[i], vflg[i]);
      end
    end
    rev_cycle(1'b0, 64'h0);
    checks++;
    if (rev_bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_valid_drop: got valid=%b, expected 0", rev_bus.out_valid);
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] vin [4] = '{32'h7F80_0001, 32'h0000_0001, 32'hBF80_0000, 32'hFFC1_2345};
    for (int i = 0; i < 4; i++) begin
      pass_cycle(1'b1, vin[i]);
      checks++;
      if (pass_bus.out_valid !== 1'b1 || pass_bus.out_fp !== vin[i] ||
          pass_bus.out_inexact !== 1'b0 || pass_bus.out_overflow !== 1'b0) begin
        failures++;
        $display("FAIL pass[%0d]: got valid=%b fp=%h inx=%b ovf=%b, expected valid=1 fp=%h inx=0 ovf=0",
                 i, pass_bus.out_valid, pass_bus.out_fp, pass_bus.out_inexact,
                 pass_bus.out_overflow, vin[i]);
      end
    end
    pass_cycle(1'b0, 32'h0);
  endtask

  task automatic test_round_trip();
    logic [31:0] v;
    logic [63:0] wide;
    int          bad = 0;
    for (int k = 0; k < 3000; k++) begin
      v = $urandom;
      if (v[30:23] == 8'hFF) v[30] = 1'b0;
      if ((k % 4) == 1) v[30:23] = 8'h00;
      fwd_cycle(1'b1, v);
      wide = fwd_bus.out_fp;
      rev_cycle(1'b1, wide);
      checks++;
      if (rev_bus.out_fp !== v || rev_bus.out_inexact !== 1'b0 || rev_bus.out_overflow !== 1'b0) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL round_trip[%0d]: wide=%h got fp=%h inx=%b ovf=%b, expected fp=%h inx=0 ovf=0",
                   k, wide, rev_bus.out_fp, rev_bus.out_inexact, rev_bus.out_overflow, v);
      end
    end
  endtask

  task automatic test_reset_mid();
    rev_cycle(1'b1, 64'h7FEF_FFFF_FFFF_FFFF);
    fwd_cycle(1'b1, 32'hC020_0000);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fwd_bus.out_valid, fwd_bus.out_fp, fwd_bus.out_inexact, fwd_bus.out_overflow} !== 67'd0) begin
      failures++;
      $display("FAIL reset_mid_fwd: got valid=%b fp=%h inx=%b ovf=%b, expected all zero",
               fwd_bus.out_valid, fwd_bus.out_fp, fwd_bus.out_inexact, fwd_bus.out_overflow);
    end
    checks++;
    if ({rev_bus.out_valid, rev_bus.out_fp, rev_bus.out_inexact, rev_bus.out_overflow} !== 35'd0) begin
      failures++;
      $display("FAIL reset_mid_rev: got valid=%b fp=%h inx=%b ovf=%b, expected all zero",
               rev_bus.out_valid, rev_bus.out_fp, rev_bus.out_inexact, rev_bus.out_overflow);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n            = 1'b1;
    fwd_bus.in_valid = 1'b0;
    rev_bus.in_valid = 1'b0;
    fwd_cycle(1'b0, 32'h3F80_0000);
    checks++;
    if (fwd_bus.out_valid !== 1'b0 || fwd_bus.out_fp !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid_idle: got valid=%b fp=%h, expected valid=0 fp=0",
               fwd_bus.out_valid, fwd_bus.out_fp);
    end
    fwd_cycle(1'b1, 32'h4049_0FDB);
    checks++;
    if (fwd_bus.out_valid !== 1'b1 || fwd_bus.out_fp !== 64'h4009_21FB_6000_0000) begin
      failures++;
      $display("FAIL reset_mid_resume: got valid=%b fp=%h, expected valid=1 fp=400921fb60000000",
               fwd_bus.out_valid, fwd_bus.out_fp);
    end
  endtask

  task automatic test_clz();
    for (int i = 0; i < 32; i++) begin
      clz_vec = 32'd1 << i;
      #1;
      checks++;
      if (clz_cnt !== 6'(31 - i)) begin
        failures++;
        $display("FAIL clz_onehot[%0d]: got %0d expected %0d", i, clz_cnt, 31 - i);
      end
    end
    clz_vec = 32'd0;
    #1;
    checks++;
    if (clz_cnt !== 6'd32) begin
      failures++;
      $display("FAIL clz_zero: got %0d expected 32", clz_cnt);
    end
    clz_vec = 32'h0001_8001;
    #1;
    checks++;
    if (clz_cnt !== 6'd15) begin
      failures++;
      $display("FAIL clz_mixed: got %0d expected 15", clz_cnt);
    end
  endtask

  initial begin
    fwd_bus.in_valid  = 1'b0;
    fwd_bus.in_fp     = '0;
    rev_bus.in_valid  = 1'b0;
    rev_bus.in_fp     = '0;
    pass_bus.in_valid = 1'b0;
    pass_bus.in_fp    = '0;
    clz_vec           = '0;

    test_reset();
    test_widen();
    test_narrow();
    test_hold();
    test_back_to_back();
    test_passthrough();
    test_round_trip();
    test_reset_mid();
    test_clz();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
